// File: rtl/md_issue_ctrl_if.sv
// Handshake bundle between the decode stage, the issue controller and the muldiv unit.
// The slave modport is the controller's view; the master modport is the surrounding pipeline/unit.
interface md_issue_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              Id_valid;
  logic [3:0]        Id_md_op;
  logic [DATA_W-1:0] Id_rs;
  logic [DATA_W-1:0] Id_rt;
  logic              Issue_ready;
  logic [3:0]        Md_op;
  logic [DATA_W-1:0] Rs_out;
  logic [DATA_W-1:0] Rt_out;
  logic [DATA_W-1:0] Md_res_in;
  logic              Md_stall;
  logic              Res_valid;
  logic              Res_ready;
  logic [DATA_W-1:0] Res_data;
  logic              Res_wen;

  modport slave (
    input  Id_valid, Id_md_op, Id_rs, Id_rt, Md_res_in, Md_stall, Res_ready,
    output Issue_ready, Md_op, Rs_out, Rt_out, Res_valid, Res_data, Res_wen
  );

  modport master (
    output Id_valid, Id_md_op, Id_rs, Id_rt, Md_res_in, Md_stall, Res_ready,
    input  Issue_ready, Md_op, Rs_out, Rt_out, Res_valid, Res_data, Res_wen
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue controller for the negedge-driven muldiv unit: IDLE -> BUSY -> RELEASE handshake.
// Optional busy watchdog enabled by defining MD_ISSUE_TIMEOUT_EN (adds output Md_timeout).
module md_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic Clk,
  input  logic Rst,
  md_issue_ctrl_if.slave bus
`ifdef MD_ISSUE_TIMEOUT_EN
  ,
  output logic Md_timeout
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MFHI = 4'b0011;
  localparam logic [3:0] OP_MFLO = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0111;

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'b0001) && (op <= 4'b1001);
  endfunction

  function automatic logic writes_gpr(input logic [3:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MUL);
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        md_op_q, md_op_d;
  logic [DATA_W-1:0] rs_out_q, rs_out_d;
  logic [DATA_W-1:0] rt_out_q, rt_out_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_wen_q, res_wen_d;

`ifdef MD_ISSUE_TIMEOUT_EN
  // The 100th BUSY edge that still sees a stall abandons the op.
  localparam logic [6:0] TMO_LAST = 7'd99;
  logic [6:0] tmo_cnt_q, tmo_cnt_d;
  logic       md_timeout_q, md_timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    md_op_d    = md_op_q;
    rs_out_d   = rs_out_q;
    rt_out_d   = rt_out_q;
    res_data_d = res_data_q;
    res_wen_d  = res_wen_q;
`ifdef MD_ISSUE_TIMEOUT_EN
    tmo_cnt_d    = '0;
    md_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Id_valid) begin
          if (is_legal(bus.Id_md_op)) begin
            md_op_d   = bus.Id_md_op;
            rs_out_d  = bus.Id_rs;
            rt_out_d  = bus.Id_rt;
            res_wen_d = writes_gpr(bus.Id_md_op);
            state_d   = BUSY;
          end else begin
            // Illegal opcodes never reach the unit and complete with an empty result.
            md_op_d    = OP_NOP;
            res_wen_d  = 1'b0;
            res_data_d = '0;
            state_d    = RELEASE;
          end
        end
      end
      BUSY: begin
        if (!bus.Md_stall) begin
          res_data_d = bus.Md_res_in;
          md_op_d    = OP_NOP;
          state_d    = RELEASE;
        end
`ifdef MD_ISSUE_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          md_op_d      = OP_NOP;
          res_wen_d    = 1'b0;
          res_data_d   = '0;
          md_timeout_d = 1'b1;
          state_d      = RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 7'd1;
        end
`endif
      end
      RELEASE: begin
        // Md_op is already NOP here so the unit drops its done flags before the next issue.
        if (bus.Res_ready) begin
          res_wen_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      md_op_q    <= OP_NOP;
      rs_out_q   <= '0;
      rt_out_q   <= '0;
      res_data_q <= '0;
      res_wen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_op_q    <= md_op_d;
      rs_out_q   <= rs_out_d;
      rt_out_q   <= rt_out_d;
      res_data_q <= res_data_d;
      res_wen_q  <= res_wen_d;
    end
  end

`ifdef MD_ISSUE_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_cnt_q    <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign Md_timeout = md_timeout_q;
`endif

  assign bus.Issue_ready = (state_q == IDLE);
  assign bus.Res_valid   = (state_q == RELEASE);
  assign bus.Md_op       = md_op_q;
  assign bus.Rs_out      = rs_out_q;
  assign bus.Rt_out      = rt_out_q;
  assign bus.Res_data    = res_data_q;
  assign bus.Res_wen     = res_wen_q && (state_q == RELEASE);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: negedge muldiv unit model, HI/LO reference model, directed and random ops.
module tb_md_issue_ctrl;

  logic Clk;
  logic Rst;
  md_issue_ctrl_if bus ();
`ifdef MD_ISSUE_TIMEOUT_EN
  logic md_timeout;
`endif

  md_issue_ctrl dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
`ifdef MD_ISSUE_TIMEOUT_EN
    ,
    .Md_timeout (md_timeout)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Muldiv unit stand-in: acts on negedge, 32-negedge divider, done flag cleared by a NOP opcode.
  logic [31:0] u_hi, u_lo;
  logic [63:0] u_prod;
  int          u_cnt;
  logic        u_done;

  always @(negedge Clk) begin
    if (Rst) begin
      u_hi <= '0; u_lo <= '0; u_cnt <= 0; u_done <= 1'b0;
      bus.Md_stall <= 1'b0; bus.Md_res_in <= '0;
    end else if (bus.Md_op == 4'd0) begin
      u_done <= 1'b0;
    end else if (!u_done) begin
      case (bus.Md_op)
        4'd1, 4'd2: begin
          if (u_cnt == 0) begin
            u_cnt <= 32; bus.Md_stall <= 1'b1;
          end else if (u_cnt == 1) begin
            if (bus.Md_op == 4'd1) begin
              u_lo <= $signed(bus.Rs_out) / $signed(bus.Rt_out);
              u_hi <= $signed(bus.Rs_out) % $signed(bus.Rt_out);
              bus.Md_res_in <= $signed(bus.Rs_out) / $signed(bus.Rt_out);
            end else begin
              u_lo <= bus.Rs_out / bus.Rt_out;
              u_hi <= bus.Rs_out % bus.Rt_out;
              bus.Md_res_in <= bus.Rs_out / bus.Rt_out;
            end
            bus.Md_stall <= 1'b0; u_done <= 1'b1; u_cnt <= 0;
          end else begin
            u_cnt <= u_cnt - 1;
          end
        end
        4'd3: begin bus.Md_res_in <= u_hi; u_done <= 1'b1; end
        4'd4: begin bus.Md_res_in <= u_lo; u_done <= 1'b1; end
        4'd5: begin u_hi <= bus.Rs_out; bus.Md_res_in <= bus.Rs_out; u_done <= 1'b1; end
        4'd6: begin u_lo <= bus.Rs_out; bus.Md_res_in <= bus.Rs_out; u_done <= 1'b1; end
        4'd7: begin bus.Md_res_in <= bus.Rs_out * bus.Rt_out; u_done <= 1'b1; end
        4'd8: begin
          u_prod = {{32{bus.Rs_out[31]}}, bus.Rs_out} * {{32{bus.Rt_out[31]}}, bus.Rt_out};
          {u_hi, u_lo} <= u_prod; bus.Md_res_in <= u_prod[31:0]; u_done <= 1'b1;
        end
        4'd9: begin
          u_prod = {32'd0, bus.Rs_out} * {32'd0, bus.Rt_out};
          {u_hi, u_lo} <= u_prod; bus.Md_res_in <= u_prod[31:0]; u_done <= 1'b1;
        end
        default: u_done <= 1'b1;
      endcase
    end
  end

  // Architectural reference: what HI/LO and the writeback should be after each op.
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  task automatic ref_apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           output logic exp_wen, output logic [31:0] exp_data, output bit known);
    longint          sp;
    longint unsigned up;
    int              a, b;
    exp_wen = 1'b0; exp_data = '0; known = 1'b0;
    a = int'(rs); b = int'(rt);
    case (op)
      4'd1: begin ref_lo = 32'(a / b); ref_hi = 32'(a % b); end
      4'd2: begin ref_lo = rs / rt; ref_hi = rs % rt; end
      4'd3: begin exp_wen = 1'b1; exp_data = ref_hi; known = 1'b1; end
      4'd4: begin exp_wen = 1'b1; exp_data = ref_lo; known = 1'b1; end
      4'd5: ref_hi = rs;
      4'd6: ref_lo = rs;
      4'd7: begin sp = longint'(a) * longint'(b); exp_wen = 1'b1; exp_data = sp[31:0]; known = 1'b1; end
      4'd8: begin sp = longint'(a) * longint'(b); ref_hi = sp[63:32]; ref_lo = sp[31:0]; end
      4'd9: begin up = longint'(rs) * longint'(rt); ref_hi = up[63:32]; ref_lo = up[31:0]; end
      default: begin exp_wen = 1'b0; exp_data = '0; known = 1'b1; end
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input int hold);
    logic        exp_wen;
    logic [31:0] exp_data, d0;
    bit          known;
    int          lat, exp_lat;
    ref_apply(op, rs, rt, exp_wen, exp_data, known);
    exp_lat = (op == 4'd0 || op > 4'd9) ? 0 : ((op == 4'd1 || op == 4'd2) ? 33 : 1);
    @(posedge Clk); #1;
    check_val("idle_ready", 32'(bus.Issue_ready), 32'd1);
    check_val("idle_mdop", 32'(bus.Md_op), 32'd0);
    bus.Id_valid = 1'b1; bus.Id_md_op = op; bus.Id_rs = rs; bus.Id_rt = rt;
    @(posedge Clk); #1;
    bus.Id_valid = 1'b0; bus.Id_md_op = 4'($urandom); bus.Id_rs = $urandom; bus.Id_rt = $urandom;
    lat = 0;
    while (!bus.Res_valid && lat < 200) begin
      check_val("busy_mdop", 32'(bus.Md_op), 32'(op));
      check_val("busy_rs", bus.Rs_out, rs);
      check_val("busy_rt", bus.Rt_out, rt);
      check_val("busy_ready", 32'(bus.Issue_ready), 32'd0);
      @(posedge Clk); #1;
      lat++;
    end
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("rel_valid", 32'(bus.Res_valid), 32'd1);
    check_val("rel_mdop", 32'(bus.Md_op), 32'd0);
    check_val("rel_wen", 32'(bus.Res_wen), 32'(exp_wen));
    if (known) check_val("rel_data", bus.Res_data, exp_data);
    d0 = bus.Res_data;
    last_data = bus.Res_data;
    repeat (hold) begin
      @(posedge Clk); #1;
      check_val("hold_valid", 32'(bus.Res_valid), 32'd1);
      check_val("hold_data", bus.Res_data, d0);
      check_val("hold_ready", 32'(bus.Issue_ready), 32'd0);
    end
    bus.Res_ready = 1'b1;
    @(posedge Clk); #1;
    bus.Res_ready = 1'b0;
    check_val("exit_valid", 32'(bus.Res_valid), 32'd0);
    check_val("exit_ready", 32'(bus.Issue_ready), 32'd1);
    check_val("exit_wen", 32'(bus.Res_wen), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ready"}, 32'(bus.Issue_ready), 32'd1);
    check_val({tag, "_mdop"}, 32'(bus.Md_op), 32'd0);
    check_val({tag, "_valid"}, 32'(bus.Res_valid), 32'd0);
    check_val({tag, "_wen"}, 32'(bus.Res_wen), 32'd0);
    check_val({tag, "_data"}, bus.Res_data, 32'd0);
    check_val({tag, "_rs"}, bus.Rs_out, 32'd0);
    check_val({tag, "_rt"}, bus.Rt_out, 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] rs, rt;
    Rst = 1'b1;
    bus.Id_valid = 1'b0; bus.Id_md_op = '0; bus.Id_rs = '0; bus.Id_rt = '0;
    bus.Res_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_state("rst0");
    Rst = 1'b0;

    do_op(4'd5, 32'h1234_5678, 32'h0, 0);
    do_op(4'd3, 32'h0, 32'h0, 0);
    check_val("mthi_mfhi", last_data, 32'h1234_5678);

    do_op(4'd7, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    check_val("mul_neg", last_data, 32'hFFFF_FFFA);

    do_op(4'd2, 32'd100, 32'd7, 1);
    do_op(4'd4, 32'h0, 32'h0, 0);
    check_val("divu_lo", last_data, 32'd14);
    do_op(4'd3, 32'h0, 32'h0, 0);
    check_val("divu_hi", last_data, 32'd2);

    do_op(4'd8, 32'd7, 32'd6, 0);
    do_op(4'd8, 32'hFFFF_FFFE, 32'd9, 0);
    do_op(4'd4, 32'h0, 32'h0, 0);
    check_val("mult_b2b", last_data, 32'hFFFF_FFEE);

    do_op(4'd6, 32'hCAFE_F00D, 32'h0, 5);
    do_op(4'd4, 32'h0, 32'h0, 5);
    check_val("mflo_hold", last_data, 32'hCAFE_F00D);

    // Abandon a divide ten cycles into BUSY.
    @(posedge Clk); #1;
    bus.Id_valid = 1'b1; bus.Id_md_op = 4'd1; bus.Id_rs = 32'd1000; bus.Id_rt = 32'd3;
    @(posedge Clk); #1;
    bus.Id_valid = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    check_val("div_busy", 32'(bus.Md_op), 32'd1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check_reset_state("rst_mid");
    ref_hi = '0; ref_lo = '0;
    do_op(4'd15, 32'hDEAD_BEEF, 32'h1, 0);
    check_val("illegal_data", last_data, 32'd0);
    do_op(4'd3, 32'h0, 32'h0, 0);
    check_val("hi_after_rst", last_data, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      rs = $urandom;
      rt = $urandom;
      if (op == 4'd1 || op == 4'd2) begin
        if (rt == 32'd0) rt = 32'd5;
        if (op == 4'd1 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd3;
      end
      do_op(op, rs, rt, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
